bcd_counter_ndigit: RTL and testbench
=====================================

# bcd_counter_ndigit

Parametrised multi-digit BCD up/down counter with validated parallel load, programmable terminal value and a cascade enable output. It extends the single-digit BCD counter used in the lab display designs to N packed digits. It feeds the seven-segment multiplexer directly, and can be chained to further instances through `tc`.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `clk` input, 1: rising-edge clock.
- `reset` input, 1: asynchronous, active-high.
- `en` input, 1: count enable; one step per enabled clock.
- `up_down` input, 1: direction; 0 = up, 1 = down.
- `load` input, 1: synchronous parallel-load request.
- `load_val` input, 4*DIGITS: packed BCD load value; digit 0 in bits [3:0].
- `limit` input, 4*DIGITS: packed BCD terminal value, i.e. the modulus minus 1. Must be legal BCD; the bench constrains this.
- `count` output, 4*DIGITS: packed BCD count.
- `tc` output, 1: terminal count; combinational, used as `en` of the next stage.
- `load_err` output, 1: registered one-cycle pulse when a load is rejected.

## Operation
- Priority: reset > load > en. When load is high, counting is suppressed in that cycle.
- Reset (asynchronous):
  - `count` = 0 if `up_down`=0; `count` = `limit` if `up_down`=1. Both inputs are sampled while reset is high.
  - `load_err` = 0.
- Load:
  - Accepted only if every digit of `load_val` is ≤ 9 and `load_val` ≤ `limit`, compared as decimal. On acceptance, `count` ← `load_val`.
  - Otherwise `count` holds and `load_err` = 1 for the following cycle.
- Up count (en=1, up_down=0):
  - Digit 0 increments. Digit i increments only when all lower digits are 9; a digit at 9 rolls to 0.
  - `count` == `limit` → next value is 0 (wrap).
  - `count` > `limit` (limit lowered at run time) → next value is 0.
- Down count (en=1, up_down=1):
  - Digit 0 decrements. Digit i decrements only when all lower digits are 0; a digit at 0 rolls to 9.
  - `count` == 0 → next value is `limit` (wrap).
  - `count` > `limit` → next value is `limit`.
- `en`=0 and no load → `count` holds.
- Direction change takes effect on the next enabled edge with no extra cycle.
- `tc` = `en` & ((`up_down`=0 & `count`==`limit`) | (`up_down`=1 & `count`==0)).
- `count` never holds a non-BCD digit in any state reachable from reset.

## Timing
- `count` and `load_err` update on the rising edge of `clk`; latency is 1 cycle from `en` or `load`.
- `tc` is combinational from `count`, `limit`, `en` and `up_down`, with no register stage. Cascaded stages therefore step on the same edge the lower stage wraps.
- Reset takes effect immediately. Reset asserted mid-count discards the count; the first step after release occurs on the first edge with `en`=1.
- `load_err` asserts only for the cycle after a rejected load. Back-to-back rejected loads keep it high continuously.
- Simultaneous `load` and `en` with an invalid `load_val`: the counter holds and does not count.

## Configuration
- `BCD_CNT_SATURATE_EN` defined:
  - Up count at `limit` holds at `limit`; down count at 0 holds at 0.
  - `tc` keeps the same definition, so it stays high while saturated and enabled.
  - The out-of-range rule (`count` > `limit`) becomes "next = `limit`" in both directions.
- `BCD_CNT_SATURATE_EN` undefined: wrap behaviour exactly as in Operation.

## Test plan
- **Wrap up:** DIGITS=4, limit=9999, reset with up_down=0, en=1 for 10000 cycles → count 0000…9999, back to 0000 on cycle 10000; tc high only while count=9999.
- **Down with modulus:** limit=0059, reset with up_down=1 → count=0059. Count down 60 cycles → 0000 then 0059; tc high only at 0000.
- **Load validation:**
  - load_val=0123 → count=0123 next cycle, load_err=0.
  - load_val=01A3 → count holds, load_err=1 for one cycle.
  - load_val=0100 with limit=0059 → rejected, load_err=1.
- **Priority and reset:** load=1, en=1, load_val=0042 → count=0042 with no increment. Assert reset mid-count with up_down=1, limit=0500 → count=0500 immediately, without waiting for a clock edge.
- **Cascade:** two DIGITS=2 instances, lower tc → upper en, both limit=99 → combined value steps 0099 → 0100 on a single edge.
- **Saturate:** with BCD_CNT_SATURATE_EN, limit=0009, up count for 15 cycles → count sticks at 0009 and tc stays high. Without the macro → count wraps to 0000 after 0009.

Source files
------------

// File: rtl/bcd_counter_ndigit.sv
// Multi-digit packed BCD up/down counter with validated load, programmable terminal value and cascade tc.
// Define BCD_CNT_SATURATE_EN to hold at the terminal value instead of wrapping.
module bcd_counter_ndigit #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      count_reg;
  logic [W-1:0]      count_next;
  logic [W-1:0]      count_inc;
  logic [W-1:0]      count_dec;
  logic              load_err_reg;
  logic [DIGITS-1:0] nine_below;
  logic [DIGITS-1:0] zero_below;
  logic [DIGITS-1:0] lv_digit_ok;
  logic              load_ok;
  logic              at_limit;
  logic              at_zero;
  logic              over_limit;

  // Ripple-carry/borrow chain: a digit steps only when every lower digit is at 9 (up) or 0 (down).
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      assign d = count_reg[4*gi +: 4];

      if (gi == 0) begin : g_first
        assign nine_below[gi] = 1'b1;
        assign zero_below[gi] = 1'b1;
      end else begin : g_rest
        assign nine_below[gi] = nine_below[gi-1] & (count_reg[4*(gi-1) +: 4] == 4'd9);
        assign zero_below[gi] = zero_below[gi-1] & (count_reg[4*(gi-1) +: 4] == 4'd0);
      end

      assign count_inc[4*gi +: 4] = !nine_below[gi] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
      assign count_dec[4*gi +: 4] = !zero_below[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
      assign lv_digit_ok[gi]      = (load_val[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  // With all digits legal BCD, packed binary ordering equals decimal ordering.
  assign at_limit   = (count_reg == limit);
  assign at_zero    = (count_reg == '0);
  assign over_limit = (count_reg > limit);
  assign load_ok    = (&lv_digit_ok) && (load_val <= limit);

  always_comb begin
    count_next = count_reg;
    if (load) begin
      if (load_ok) count_next = load_val;
    end else if (en) begin
      if (!up_down) begin
`ifdef BCD_CNT_SATURATE_EN
        if (over_limit || at_limit) count_next = limit;
        else                        count_next = count_inc;
`else
        if (over_limit || at_limit) count_next = '0;
        else                        count_next = count_inc;
`endif
      end else begin
        if (over_limit) begin
          count_next = limit;
        end else if (at_zero) begin
`ifdef BCD_CNT_SATURATE_EN
          count_next = count_reg;
`else
          count_next = limit;
`endif
        end else begin
          count_next = count_dec;
        end
      end
    end
  end

  // Reset value follows direction so a down counter starts at its terminal value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= up_down ? limit : '0;
      load_err_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      load_err_reg <= load & ~load_ok;
    end
  end

  assign count    = count_reg;
  assign load_err = load_err_reg;
  assign tc       = en & (up_down ? at_zero : at_limit);

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Scoreboard bench for bcd_counter_ndigit: a decimal-integer reference model predicts each cycle,
// a monitor compares the DUT; also covers async reset and a two-stage cascade.
module tb_bcd_counter_ndigit;

`ifdef BCD_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        up_down = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] limit = 16'h9999;
  logic [15:0] count;
  logic        tc;
  logic        load_err;

  logic       c_reset = 1'b0;
  logic       c_en = 1'b0;
  logic       c_load = 1'b0;
  logic [7:0] c_lo_val = '0;
  logic [7:0] c_hi_val = '0;
  logic [7:0] lo_count, hi_count;
  logic       lo_tc, hi_tc, lo_err, hi_err;

  always #5 clk = ~clk;

  bcd_counter_ndigit #(.DIGITS(4)) dut (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .limit(limit), .count(count), .tc(tc), .load_err(load_err)
  );

  bcd_counter_ndigit #(.DIGITS(2)) lo (
    .clk(clk), .reset(c_reset), .en(c_en), .up_down(1'b0), .load(c_load),
    .load_val(c_lo_val), .limit(8'h99), .count(lo_count), .tc(lo_tc), .load_err(lo_err)
  );

  bcd_counter_ndigit #(.DIGITS(2)) hi (
    .clk(clk), .reset(c_reset), .en(lo_tc), .up_down(1'b0), .load(c_load),
    .load_val(c_hi_val), .limit(8'h99), .count(hi_count), .tc(hi_tc), .load_err(hi_err)
  );

  typedef struct {
    logic [15:0] cnt;
    logic        err;
    logic        tc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   vectors = 0;
  int   miscompares = 0;
  int   txn = 0;
  int   m_cnt = 0;
  int   m_lim = 9999;
  bit   m_err = 1'b0;

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] n;
      n = v[4*i +: 4];
      if (n > 4'd9) return -1;
      r = r * 10 + int'(n);
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x);
    logic [15:0] r;
    int y = x;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the model's prediction.
  task automatic step(input logic e, input logic u, input logic l,
                      input logic [15:0] lv, input logic [15:0] lim);
    exp_t x;
    int   v;
    @(posedge clk); #1;
    en = e; up_down = u; load = l; load_val = lv; limit = lim;
    m_lim = bcd2int(lim);
    x.tc  = e && (u ? (m_cnt == 0) : (m_cnt == m_lim));
    if (l) begin
      v = bcd2int(lv);
      if (v >= 0 && v <= m_lim) begin
        m_cnt = v;
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_err = 1'b0;
      if (e) begin
        if (!u) begin
          if (m_cnt >= m_lim) m_cnt = SAT ? m_lim : 0;
          else                m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt > m_lim)   m_cnt = m_lim;
          else if (m_cnt == 0) m_cnt = SAT ? 0 : m_lim;
          else                 m_cnt = m_cnt - 1;
        end
      end
    end
    x.cnt = int2bcd(m_cnt);
    x.err = m_err;
    sb.push_back(x);
  endtask

  // Asserts reset between clock edges and checks it acts without waiting for an edge.
  task automatic do_reset(input logic u, input logic [15:0] lim);
    @(posedge clk); #1;
    en = 1'b0; load = 1'b0;
    #2;
    up_down = u; limit = lim; reset = 1'b1;
    #1;
    check16("reset_count", count, u ? lim : 16'h0000);
    check1("reset_load_err", load_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_lim = bcd2int(lim);
    m_cnt = u ? m_lim : 0;
    m_err = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        check1("tc", tc, sb[0].tc);
        @(posedge clk); #2;
        mon_x = sb.pop_front();
        check16("count", count, mon_x.cnt);
        check1("load_err", load_err, mon_x.err);
        txn++;
        $display("txn %0d: count=%h load_err=%b tc=%b", txn, count, load_err, tc);
      end
    end
  end

  initial begin
    logic [15:0] r_lim;
    logic [15:0] lv;

    do_reset(1'b0, 16'h9999);
    repeat (10001) step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999);

    do_reset(1'b1, 16'h0059);
    repeat (62) step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0059);

    step(1'b0, 1'b0, 1'b1, 16'h0123, 16'h9999);
    step(1'b0, 1'b0, 1'b1, 16'h01A3, 16'h9999);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999);
    step(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0059);
    step(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0059);
    step(1'b1, 1'b0, 1'b1, 16'h0042, 16'h9999);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h9999);

    // Limit lowered below the current count in each direction.
    step(1'b0, 1'b0, 1'b1, 16'h0500, 16'h9999);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0100);
    step(1'b0, 1'b1, 1'b1, 16'h0500, 16'h9999);
    step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0100);

    r_lim = 16'h0099;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) r_lim = int2bcd(int'($urandom_range(0, 9999)));
      if ($urandom_range(0, 3) == 0) lv = 16'($urandom);
      else                           lv = int2bcd(int'($urandom_range(0, bcd2int(r_lim))));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), lv, r_lim);
    end

    repeat (5) step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999);
    do_reset(1'b1, 16'h0500);
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0500);

    // Cascade: lower stage wrapping steps the upper stage on the same edge.
    @(posedge clk); #3;
    c_reset = 1'b1; #1;
    c_reset = 1'b0;
    check16("cascade_reset", {hi_count, lo_count}, 16'h0000);
    c_load = 1'b1; c_lo_val = 8'h99; c_hi_val = 8'h00; c_en = 1'b0;
    @(posedge clk); #1;
    c_load = 1'b0; c_en = 1'b1;
    check16("cascade_loaded", {hi_count, lo_count}, 16'h0099);
    #1;
    check1("cascade_lo_tc", lo_tc, 1'b1);
    @(posedge clk); #1;
    c_en = 1'b0;
    check16("cascade_step", {hi_count, lo_count}, 16'h0100);

    repeat (4) @(posedge clk);
    #3;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
